hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed Tuse/Tnew hazard decode. Tracks in-flight register writers across a configurable pipeline depth and issues stall/forward decisions for the D stage.
- Adds a multiply/divide busy counter, a flush input, and a stall performance counter.
- Sits beside the D-stage decoder. Consumes its Tuse/Tnew/A3 fields and drives the F/D enables, the E-stage bubble and the forwarding muxes.

---
 rtl/hazard_scoreboard_pkg.sv | 26 ++
 rtl/hazard_src_match.sv | 60 ++++++
 rtl/hazard_scoreboard.sv | 176 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the D-stage hazard scoreboard: Tnew/Tuse stage
// values, the register-file forward select code and default mult/div latencies.
package hazard_scoreboard_pkg;

    // Tnew/Tuse stage constants (cycles until a value exists / is needed)
    localparam int PC_T  = 0;
    localparam int ALU_T = 1;
    localparam int DM_T  = 2;

    // Forward select code meaning "take the operand from the register file"
    localparam int FWD_RF = 0;

    // Default busy times of the multiply/divide unit
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // Larger of two integers, used for sizing counters at elaboration time
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            max_int = a;
        end else begin
            max_int = b;
        end
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-source hazard check: finds the youngest in-flight writer of one D-stage
// source register and decides whether D must stall or can forward from it.
module hazard_src_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int AW     = 5,
    parameter int TW     = 3,
    localparam int FSW   = $clog2(STAGES + 1)
) (
    input  logic                       use_s,
    input  logic [AW-1:0]              src,
    input  logic [TW-1:0]              tuse,
    input  logic [STAGES-1:0]          ent_valid,
    input  logic [STAGES-1:0][AW-1:0]  ent_a3,
    input  logic [STAGES-1:0][TW-1:0]  ent_tnew,
    output logic                       stall_s,
    output logic [FSW-1:0]             fwd_sel_s
);

    logic           hit_s;
    logic [TW-1:0]  hit_tnew_s;
    logic [FSW-1:0] hit_k_s;

    // Priority search from oldest to youngest so the youngest matching writer wins
    always_comb begin
        hit_s      = 1'b0;
        hit_tnew_s = '0;
        hit_k_s    = FSW'(FWD_RF);
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (use_s && (src != '0) && ent_valid[k] && (ent_a3[k] == src)) begin
                hit_s      = 1'b1;
                hit_tnew_s = ent_tnew[k];
                hit_k_s    = FSW'(k + 1);
            end else begin
                hit_s      = hit_s;
                hit_tnew_s = hit_tnew_s;
                hit_k_s    = hit_k_s;
            end
        end
    end

    // Stall when the producer is too late for the consumer; forward once ready
    always_comb begin
        stall_s   = 1'b0;
        fwd_sel_s = FSW'(FWD_RF);
        if (hit_s) begin
            stall_s = (hit_tnew_s > tuse);
            if (hit_tnew_s == '0) begin
                fwd_sel_s = hit_k_s;
            end else begin
                fwd_sel_s = FSW'(FWD_RF);
            end
        end else begin
            stall_s   = 1'b0;
            fwd_sel_s = FSW'(FWD_RF);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: tracks in-flight register writers after D,
// produces stall and forward selects, models mult/div occupancy and counts
// stalled cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int TW       = 3,
    parameter int NREG     = 32,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    localparam int AW      = $clog2(NREG),
    localparam int FSW     = $clog2(STAGES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            d_valid,
    input  logic [AW-1:0]   d_rs,
    input  logic [AW-1:0]   d_rt,
    input  logic            d_use_rs,
    input  logic            d_use_rt,
    input  logic [TW-1:0]   d_tuse_rs,
    input  logic [TW-1:0]   d_tuse_rt,
    input  logic            d_regwrite,
    input  logic [AW-1:0]   d_a3,
    input  logic [TW-1:0]   d_tnew,
    input  logic            d_md,
    input  logic            d_md_start,
    input  logic            d_md_div,
    input  logic            flush,
    output logic            stall,
    output logic [FSW-1:0]  fwd_rs_sel,
    output logic [FSW-1:0]  fwd_rt_sel,
    output logic            md_busy,
    output logic [31:0]     stall_cnt
);

    localparam int MDW = $clog2(max_int(MULT_LAT, DIV_LAT) + 1);

    // Tracked entries; index 0 is the E stage (stage 1)
    logic [STAGES-1:0]          ent_valid_q, ent_valid_d;
    logic [STAGES-1:0][AW-1:0]  ent_a3_q,    ent_a3_d;
    logic [STAGES-1:0][TW-1:0]  ent_tnew_q,  ent_tnew_d;
    logic                       e_md_start_q, e_md_start_d;
    logic [MDW-1:0]             md_cnt_q,    md_cnt_d;
    logic [31:0]                stall_cnt_q, stall_cnt_d;

    logic                       stall_rs_s, stall_rt_s;
    logic                       md_stall_s;
    logic                       stall_s;
    logic                       accept_s;

    // Tnew count-down that stops at zero once the value exists
    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
        if (v == '0) begin
            sat_dec = '0;
        end else begin
            sat_dec = v - TW'(1);
        end
    endfunction

    hazard_src_match #(
        .STAGES (STAGES),
        .AW     (AW),
        .TW     (TW)
    ) u_match_rs (
        .use_s     (d_use_rs),
        .src       (d_rs),
        .tuse      (d_tuse_rs),
        .ent_valid (ent_valid_q),
        .ent_a3    (ent_a3_q),
        .ent_tnew  (ent_tnew_q),
        .stall_s   (stall_rs_s),
        .fwd_sel_s (fwd_rs_sel)
    );

    hazard_src_match #(
        .STAGES (STAGES),
        .AW     (AW),
        .TW     (TW)
    ) u_match_rt (
        .use_s     (d_use_rt),
        .src       (d_rt),
        .tuse      (d_tuse_rt),
        .ent_valid (ent_valid_q),
        .ent_a3    (ent_a3_q),
        .ent_tnew  (ent_tnew_q),
        .stall_s   (stall_rt_s),
        .fwd_sel_s (fwd_rt_sel)
    );

    // Combine data hazards with the mult/div occupancy hazard
    always_comb begin
        md_busy    = (md_cnt_q != '0);
        md_stall_s = d_valid && d_md && (md_busy || e_md_start_q);
        stall_s    = d_valid && (stall_rs_s || stall_rt_s || md_stall_s);
        accept_s   = d_valid && !stall_s && !flush;
        stall      = stall_s;
        stall_cnt  = stall_cnt_q;
    end

    // Next state of the tracked entries: shift toward retirement, load E from D
    always_comb begin
        ent_valid_d  = '0;
        ent_a3_d     = '0;
        ent_tnew_d   = '0;
        e_md_start_d = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            ent_valid_d[k] = ent_valid_q[k-1];
            ent_a3_d[k]    = ent_a3_q[k-1];
            ent_tnew_d[k]  = sat_dec(ent_tnew_q[k-1]);
        end
        if (flush) begin
            // A flushed cycle empties the whole tracked window, D included
            ent_valid_d  = '0;
            e_md_start_d = 1'b0;
        end else if (accept_s) begin
            ent_valid_d[0] = d_regwrite && (d_a3 != '0);
            ent_a3_d[0]    = d_a3;
            ent_tnew_d[0]  = d_tnew;
            e_md_start_d   = d_md_start;
        end else begin
            // Stalled or empty D: a bubble enters E
            ent_valid_d[0] = 1'b0;
            ent_a3_d[0]    = '0;
            ent_tnew_d[0]  = '0;
            e_md_start_d   = 1'b0;
        end
    end

    // Mult/div busy counter: loads when a start enters E, otherwise drains;
    // a flush does not abandon an operation already issued
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (accept_s && d_md_start) begin
            if (d_md_div) begin
                md_cnt_d = MDW'(DIV_LAT);
            end else begin
                md_cnt_d = MDW'(MULT_LAT);
            end
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MDW'(1);
        end else begin
            md_cnt_d = '0;
        end
    end

    // Stall performance counter, wraps naturally at 2^32
    always_comb begin
        if (stall_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            ent_valid_q  <= '0;
            ent_a3_q     <= '0;
            ent_tnew_q   <= '0;
            e_md_start_q <= 1'b0;
            md_cnt_q     <= '0;
            stall_cnt_q  <= 32'd0;
        end else begin
            ent_valid_q  <= ent_valid_d;
            ent_a3_q     <= ent_a3_d;
            ent_tnew_q   <= ent_tnew_d;
            e_md_start_q <= e_md_start_d;
            md_cnt_q     <= md_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        d_valid;
    logic [4:0]  d_rs, d_rt, d_a3;
    logic        d_use_rs, d_use_rt;
    logic [2:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        d_regwrite, d_md, d_md_start, d_md_div, flush;
    logic        stall, md_busy;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_use_rs   (d_use_rs),
        .d_use_rt   (d_use_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_regwrite (d_regwrite),
        .d_a3       (d_a3),
        .d_tnew     (d_tnew),
        .d_md       (d_md),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .flush      (flush),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        d_valid = 1'b0; d_rs = 5'd0; d_rt = 5'd0; d_a3 = 5'd0;
        d_use_rs = 1'b0; d_use_rt = 1'b0;
        d_tuse_rs = 3'd0; d_tuse_rt = 3'd0; d_tnew = 3'd0;
        d_regwrite = 1'b0; d_md = 1'b0; d_md_start = 1'b0; d_md_div = 1'b0;
        flush = 1'b0;
    endtask

    // Present one instruction in D
    task automatic drive(input logic [4:0] rs, input logic urs, input logic [2:0] trs,
                         input logic [4:0] rt, input logic urt, input logic [2:0] trt,
                         input logic rw, input logic [4:0] a3, input logic [2:0] tn,
                         input logic md, input logic mds, input logic mdd);
        d_valid = 1'b1;
        d_rs = rs; d_use_rs = urs; d_tuse_rs = trs;
        d_rt = rt; d_use_rt = urt; d_tuse_rt = trt;
        d_regwrite = rw; d_a3 = a3; d_tnew = tn;
        d_md = md; d_md_start = mds; d_md_div = mdd;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_idle();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        checks++; if (fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL reset_fwd_rs: got %0d expected 0", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL reset_fwd_rt: got %0d expected 0", fwd_rt_sel); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy: got %0b expected 0", md_busy); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    // lw $8 (tnew 2) then addu reading $8 (tuse 1): one stall cycle
    task automatic test_load_use();
        do_reset();
        drive(5'd29, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0, 1'b1, 5'd8, 3'd2, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_issue_stall: got %0b expected 0", stall); end
        tick();
        drive(5'd8, 1'b1, 3'd1, 5'd9, 1'b1, 3'd1, 1'b1, 5'd10, 3'd1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_use_stall: got %0b expected 1", stall); end
        tick();
        #1;
        // lw now in M with tnew 1: no stall, value not yet forwardable
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_use_release: got %0b expected 0", stall); end
        checks++; if (fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL lw_use_fwd_m: got %0d expected 0", fwd_rs_sel); end
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lw_use_cnt: got %0d expected 1", stall_cnt); end
        tick();
        // lw in W (tnew 0), addu $10 in E (tnew 1); reader with tuse 0 on $8, tuse 1 on $10
        drive(5'd8, 1'b1, 3'd0, 5'd10, 1'b1, 3'd1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_w_stall: got %0b expected 0", stall); end
        checks++; if (fwd_rs_sel !== 2'd3) begin errors++; $display("FAIL lw_w_fwd_rs: got %0d expected 3", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL lw_w_fwd_rt: got %0d expected 0", fwd_rt_sel); end
    endtask

    // addu $9 (tnew 1) then beq on $9 (tuse 0)
    task automatic test_alu_branch();
        do_reset();
        drive(5'd1, 1'b1, 3'd1, 5'd2, 1'b1, 3'd1, 1'b1, 5'd9, 3'd1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd9, 1'b1, 3'd0, 5'd3, 1'b1, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_stall: got %0b expected 1", stall); end
        tick();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_release: got %0b expected 0", stall); end
        checks++; if (fwd_rs_sel !== 2'd2) begin errors++; $display("FAIL br_fwd_rs: got %0d expected 2", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL br_fwd_rt: got %0d expected 0", fwd_rt_sel); end
        tick();
        drive(5'd4, 1'b1, 3'd0, 5'd6, 1'b1, 3'd0, 1'b1, 5'd7, 3'd1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL indep_stall: got %0b expected 0", stall); end
        checks++; if (fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL indep_fwd_rs: got %0d expected 0", fwd_rs_sel); end
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL br_cnt: got %0d expected 1", stall_cnt); end
    endtask

    // Two writers of $5 in flight: youngest wins; $0 never matches
    task automatic test_youngest_and_zero();
        do_reset();
        drive(5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 1'b1, 5'd5, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 1'b1, 5'd5, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd5, 1'b1, 3'd0, 5'd5, 1'b1, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (fwd_rs_sel !== 2'd1) begin errors++; $display("FAIL young_fwd_rs: got %0d expected 1", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== 2'd1) begin errors++; $display("FAIL young_fwd_rt: got %0d expected 1", fwd_rt_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL young_stall: got %0b expected 0", stall); end
        tick();
        drive(5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 1'b1, 5'd0, 3'd2, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 1'b1, 3'd0, 5'd0, 1'b1, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %0b expected 0", stall); end
        checks++; if (fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL zero_fwd_rs: got %0d expected 0", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL zero_fwd_rt: got %0d expected 0", fwd_rt_sel); end
    endtask

    // mult/div start followed immediately by mflo
    task automatic test_md(input logic is_div, input int lat);
        do_reset();
        drive(5'd1, 1'b1, 3'd1, 5'd2, 1'b1, 3'd1, 1'b0, 5'd0, 3'd0, 1'b1, 1'b1, is_div);
        #1;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL md_pre_busy: got %0b expected 0", md_busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL md_start_stall: got %0b expected 0", stall); end
        tick();
        drive(5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 1'b1, 5'd3, 3'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < lat; i++) begin
            #1;
            checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL md_busy_c%0d: got %0b expected 1", i, md_busy); end
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL md_mflo_stall_c%0d: got %0b expected 1", i, stall); end
            tick();
        end
        #1;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL md_done_busy: got %0b expected 0", md_busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL md_done_stall: got %0b expected 0", stall); end
        checks++; if (stall_cnt !== 32'(lat)) begin errors++; $display("FAIL md_cnt: got %0d expected %0d", stall_cnt, lat); end
        tick();
        set_idle();
    endtask

    // flush while lw $8 is in E and a dependent sits in D
    task automatic test_flush();
        do_reset();
        drive(5'd29, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0, 1'b1, 5'd8, 3'd2, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd8, 1'b1, 3'd0, 5'd8, 1'b1, 3'd0, 1'b1, 5'd11, 3'd1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %0b expected 1", stall); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b expected 0", stall); end
        checks++; if (fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL flush_fwd_rs: got %0d expected 0", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL flush_fwd_rt: got %0d expected 0", fwd_rt_sel); end
        set_idle();
    endtask

    // reset pulse during an md stall
    task automatic test_reset_mid();
        do_reset();
        drive(5'd1, 1'b1, 3'd1, 5'd2, 1'b1, 3'd1, 1'b0, 5'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 1'b1, 5'd3, 3'd1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmid_pre_stall: got %0b expected 1", stall); end
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL rmid_pre_busy: got %0b expected 1", md_busy); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %0b expected 0", stall); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b expected 0", md_busy); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rmid_cnt: got %0d expected 0", stall_cnt); end
        set_idle();
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        test_reset();
        test_load_use();
        test_alu_branch();
        test_youngest_and_zero();
        test_md(1'b0, 5);
        test_md(1'b1, 10);
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
